// File: rtl/pipeline_controller.sv
// Pipeline hazard/stall controller: generates latch enables and flushes for the
// five-stage pipeline, tracks a sticky halt and counts PC-stalled cycles.
module pipeline_controller (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dmemREN,
  input  logic        exmem_dmemWEN,
  input  logic        branch_taken,
  input  logic        idex_dmemREN,
  input  logic [4:0]  idex_dest,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        memwb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        memwb_flush,
  output logic        halt,
  output logic [15:0] stall_count
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DWAIT  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       dmem_miss;
  logic       load_use;

  assign dmem_miss = (exmem_dmemREN || exmem_dmemWEN) && !dhit;
  assign load_use  = idex_dmemREN && (idex_dest != 5'd0) &&
                     ((idex_dest == ifid_rs) || (idex_dest == ifid_rt));

  // Priority chain: halted, halt arrival, dmem miss, branch, load-use, imiss, run.
  // Outputs are gated by nRST so they drop to zero the moment reset asserts.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    next_state  = RUN;
    if (!nRST) begin
      next_state = RUN;
    end else if (state == HALTED) begin
      next_state = HALTED;
    end else if (memwb_halt) begin
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
      next_state  = HALTED;
    end else if (dmem_miss) begin
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
      next_state  = DWAIT;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == HALTED) begin
        halt <= 1'b1;
      end
    end
  end

  // Saturating count of cycles where the PC was held outside HALTED.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count <= 16'd0;
    end else if (!pc_en && (state != HALTED) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule
